// File: rtl/mp3_ram_fetcher_pkg.sv
// mp3_ram_fetcher_pkg: fetch FSM states and MP3 stream word width
package mp3_ram_fetcher_pkg;
  localparam int WORD_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT} fetchState_t;
endpackage

// File: rtl/mp3_ram_fetcher_fifo.sv
// mp3_word_fifo: first-word fall-through synchronous FIFO with flush
module mp3_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic [WIDTH-1:0] pushData,
  input  logic pop,
  output logic [WIDTH-1:0] popData,
  output logic [PTR_WIDTH:0] count,
  output logic empty,
  output logic full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign empty = count == '0;
  assign full = count == (PTR_WIDTH+1)'(DEPTH);
  assign doPush = push & ~full & ~flush;
  assign doPop = pop & ~empty & ~flush;
  assign popData = mem[rdPtr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr <= wrPtr + PTR_WIDTH'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_WIDTH'(1);
      count <= count + (PTR_WIDTH+1)'(doPush) - (PTR_WIDTH+1)'(doPop);
    end
endmodule

// File: rtl/mp3_ram_fetcher.sv
// mp3_ram_fetcher: prefetches MP3 stream words from RAM into a small FIFO
module mp3_ram_fetcher
  import mp3_ram_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int _FIFO_PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic addrWrite,
  input  logic [ADDR_WIDTH-1:0] addrWData,
  output logic ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic ramReq,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  input  logic ramGrant,
  input  logic ramRDataValid,
  input  logic [WORD_WIDTH-1:0] ramRData,
  output logic [WORD_WIDTH-1:0] dataOut,
  output logic dataReady,
  input  logic dataAck
);
  localparam logic [_FIFO_PTR_WIDTH:0] FULL_COUNT = (_FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);
  fetchState_t state, nextState;
  logic [_FIFO_PTR_WIDTH:0] fifoCount;
  logic fifoEmpty, fifoFull, seek, fifoPush;
  assign ready = state != WAIT;
  assign seek = addrWrite & ready;
  assign ramReq = state == REQUEST;
  assign ramAddr = addr;
  assign dataReady = ~fifoEmpty;
  assign fifoPush = (state == WAIT) & ramRDataValid & ~fifoFull;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
    end else begin
      state <= nextState;
      if (seek) addr <= addrWData & ~ADDR_WIDTH'(1);
      else if (ramReq & ramGrant) addr <= addr + ADDR_WIDTH'(2);
    end
  // a seek in REQUEST beats a same-cycle grant; the orphaned data is never pushed
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (enable & (fifoCount < FULL_COUNT) & ~addrWrite) nextState = REQUEST;
      REQUEST: nextState = addrWrite ? IDLE : ramGrant ? WAIT : enable ? REQUEST : IDLE;
      WAIT: if (ramRDataValid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  mp3_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_WIDTH), .PTR_WIDTH(_FIFO_PTR_WIDTH)) fifo (
    .clk(clk),
    .reset(reset),
    .flush(seek),
    .push(fifoPush),
    .pushData(ramRData),
    .pop(dataAck),
    .popData(dataOut),
    .count(fifoCount),
    .empty(fifoEmpty),
    .full(fifoFull)
  );
endmodule

// File: tb/tb_mp3_ram_fetcher.sv
// tb_mp3_ram_fetcher: scoreboard bench with a latency-3 RAM responder and an acking consumer
module tb_mp3_ram_fetcher;
  localparam int LAT = 3;
  logic clk = 0, reset = 1, enable = 0, addrWrite = 0, ramGrant = 0, ramRDataValid = 0, dataAck = 0;
  logic [31:0] addrWData = 0;
  logic [15:0] ramRData = 0;
  logic ready, ramReq, dataReady;
  logic [31:0] addr, ramAddr;
  logic [15:0] dataOut;
  int checks = 0, errors = 0, grantCnt = 0, ackCnt = 0, overlap = 0, lat;
  logic [31:0] expReqQ[$];
  logic [15:0] expDataQ[$];
  logic [31:0] reqAddr, expA, saved;
  logic [15:0] expD;

  mp3_ram_fetcher dut (
    .clk(clk), .reset(reset), .enable(enable), .addrWrite(addrWrite), .addrWData(addrWData),
    .ready(ready), .addr(addr), .ramReq(ramReq), .ramAddr(ramAddr), .ramGrant(ramGrant),
    .ramRDataValid(ramRDataValid), .ramRData(ramRData), .dataOut(dataOut),
    .dataReady(dataReady), .dataAck(dataAck)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RAM arbiter model: grant immediately, return data LAT cycles after the grant
  initial forever begin
    @(negedge clk);
    if (ramReq) begin
      reqAddr = ramAddr;
      checks++;
      if (expReqQ.size() == 0) begin
        errors++;
        $display("FAIL req_addr actual=%h required=none", reqAddr);
      end else begin
        expA = expReqQ.pop_front();
        if (reqAddr !== expA) begin
          errors++;
          $display("FAIL req_addr actual=%h required=%h", reqAddr, expA);
        end
      end
      grantCnt++;
      ramGrant = 1;
      @(negedge clk);
      ramGrant = 0;
      repeat (LAT - 1) @(negedge clk);
      ramRDataValid = 1;
      ramRData = memWord(reqAddr);
      @(negedge clk);
      ramRDataValid = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (ramReq && !ready) overlap++;
    if (dataAck && dataReady && !(addrWrite && ready)) begin
      ackCnt++;
      checks++;
      if (expDataQ.size() == 0) begin
        errors++;
        $display("FAIL data_out actual=%h required=none", dataOut);
      end else begin
        expD = expDataQ.pop_front();
        if (dataOut !== expD) begin
          errors++;
          $display("FAIL data_out actual=%h required=%h", dataOut, expD);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic seek(input logic [31:0] a, input int n, input logic ackToo);
    logic [31:0] al;
    al = a & 32'hFFFF_FFFE;
    addrWrite = 1;
    addrWData = a;
    dataAck = ackToo;
    expReqQ.delete();
    expDataQ.delete();
    for (int k = 0; k < n; k++) begin
      expReqQ.push_back(al + 32'(2 * k));
      expDataQ.push_back(memWord(al + 32'(2 * k)));
    end
    @(negedge clk); #1;
    addrWrite = 0;
    dataAck = 0;
    chk("seek_addr", addr, al);
    chk("seek_flush", {31'b0, dataReady}, 0);
  endtask

  task automatic consume(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (!dataReady && t < 200) begin
        @(negedge clk); #1;
        t++;
      end
      if (t == 200) begin
        checks++;
        errors++;
        $display("FAIL consume_wait actual=timeout required=dataReady");
      end
      dataAck = 1;
      @(negedge clk); #1;
      dataAck = 0;
      repeat (gap - 1) begin
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic waitReady(input logic lvl, input string nm);
    int t;
    t = 0;
    while (ready !== lvl && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk(nm, {31'b0, ready}, {31'b0, lvl});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", {31'b0, ready}, 1);
    chk("reset_addr", addr, 0);
    chk("reset_ramReq", {31'b0, ramReq}, 0);
    chk("reset_dataReady", {31'b0, dataReady}, 0);
    chk("reset_dataOut", {16'b0, dataOut}, 0);
    reset = 0;
    @(negedge clk); #1;
    // stream fill and first-word latency
    seek(32'h0000_1000, 80, 0);
    enable = 1;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk); #1;
      if (dataReady) break;
    end
    chk("first_word_latency", lat, LAT + 2);
    chk("first_word", {16'b0, dataOut}, 32'h4A5A);
    repeat (40) @(negedge clk);
    #1;
    chk("fill_grants", grantCnt, 4);
    chk("fill_addr", addr, 32'h0000_1008);
    chk("fill_ready", {31'b0, ready}, 1);
    chk("fill_dataReady", {31'b0, dataReady}, 1);
    // backpressure: one ack per 8 cycles
    consume(64, 8);
    repeat (20) @(negedge clk);
    #1;
    chk("bp_grants", grantCnt, 68);
    chk("bp_addr", addr, 32'h0000_1088);
    chk("bp_acks", ackCnt, 64);
    chk("bp_overlap", overlap, 0);
    // seek with 3 words buffered, ack in the same cycle as the flush
    enable = 0;
    repeat (3) begin
      @(negedge clk); #1;
    end
    consume(1, 1);
    chk("seek_pre_dataReady", {31'b0, dataReady}, 1);
    seek(32'h0000_2000, 40, 1);
    enable = 1;
    consume(6, 2);
    chk("seek_acks", ackCnt, 71);
    // seek rejected during WAIT, then accepted with an odd address
    consume(1, 1);
    waitReady(0, "reject_wait");
    saved = addr;
    enable = 0;
    addrWrite = 1;
    addrWData = 32'h0000_3000;
    @(negedge clk); #1;
    addrWrite = 0;
    chk("reject_addr", addr, saved);
    waitReady(1, "reject_ready");
    repeat (4) begin
      @(negedge clk); #1;
    end
    seek(32'h0000_3001, 8, 0);
    // address wrap
    seek(32'hFFFF_FFFE, 40, 0);
    enable = 1;
    consume(3, 2);
    // async reset during WAIT
    consume(1, 1);
    waitReady(0, "rst_wait");
    enable = 0;
    reset = 1;
    #1;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_addr", addr, 0);
    chk("rst_ramReq", {31'b0, ramReq}, 0);
    chk("rst_dataReady", {31'b0, dataReady}, 0);
    chk("rst_dataOut", {16'b0, dataOut}, 0);
    expDataQ.delete();
    expReqQ.delete();
    @(negedge clk); #1;
    reset = 0;
    repeat (8) begin
      @(negedge clk); #1;
    end
    chk("stale_dataReady", {31'b0, dataReady}, 0);
    chk("stale_ready", {31'b0, ready}, 1);
    chk("stale_addr", addr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
